z80_io_sequencer: RTL and testbench
===================================

Name: z80_io_sequencer

Overview:
Sequences every Z80 I/O cycle on the T35 board. It detects IORQ read/write cycles and latches port address and write data. It then holds the CPU with WAIT while the access is served: by a T35-internal port, selected via the port decoder chip selects, or by an S100 bus port, selected by default. It emits single-cycle read/write strobes, runs the S100 ready handshake with a minimum wait count and a timeout, and releases the CPU.

Parameters:
LOCAL_WAITS, 1, extra WAIT cycles after the strobe for T35-internal ports (0..15)
BUS_MIN_WAITS, 2, minimum WAIT cycles on an S100 access before RDY is sampled (0..15)
BUS_TIMEOUT, 255, maximum cycles spent waiting for s100_rdy before a forced release (1..255)

Ports:
clock  in  1  system clock; all Z80 and S100 inputs are synchronous to it
reset  in  1  synchronous, active-high
iorq_n  in  1  Z80 IORQ, active low
rd_n  in  1  Z80 RD, active low
wr_n  in  1  Z80 WR, active low
m1_n  in  1  Z80 M1, active low; IORQ with M1 low is interrupt acknowledge and is ignored
address  in  8  Z80 A[7:0]
cpu_dout  in  8  Z80 data out
local_sel  in  1  OR of the port decoder chip selects for the current address; 1 = T35-internal port
s100_rdy  in  1  S100 ready, active high
wait_n  out  1  Z80 WAIT, active low
port_addr  out  8  latched port address
wr_data  out  8  latched write data
io_rd_strb  out  1  one-clock read strobe
io_wr_strb  out  1  one-clock write strobe
s100_cycle  out  1  S100 I/O cycle in progress
busy  out  1  sequencer not idle
timeout_err  out  1  sticky flag, set on a bus timeout

Behaviour:
- Reset values: wait_n=1, strobes=0, s100_cycle=0, busy=0, timeout_err=0, port_addr=0, wr_data=0. FSM goes to IDLE. The wait and timeout counters are set to 0.
- Reset takes priority in any state. It releases wait_n in the same clock edge and abandons the cycle with no strobe.
- Start: in IDLE, a registered falling edge of iorq_n with m1_n=1 and exactly one of rd_n or wr_n low starts a cycle.
  - If both rd_n and wr_n are low or both are high, the cycle is ignored.
  - IORQ held low across IDLE never retriggers a cycle.
- States:
  - IDLE: busy=0.
  - LATCH (1 clk): capture address, cpu_dout (write only), direction and local_sel. Drive wait_n=0 and busy=1. Next state is LOCAL if local_sel=1, else BUS.
  - LOCAL: io_rd_strb or io_wr_strb pulses high for exactly the first clock. Hold wait_n=0 for LOCAL_WAITS further clocks. LOCAL_WAITS=0 goes to RELEASE immediately after the strobe clock.
  - BUS: s100_cycle=1 and the strobe pulses on the first clock.
    - Count BUS_MIN_WAITS clocks, then sample s100_rdy each clock. s100_rdy=1 goes to RELEASE.
    - The timeout counter starts on BUS entry. At BUS_TIMEOUT clocks without RDY, set timeout_err and go to RELEASE.
    - RDY and timeout on the same clock count as RDY; timeout_err is not set.
  - RELEASE: wait_n=1 and s100_cycle=0. Wait for iorq_n=1, then go to IDLE.
- Latency: wait_n falls 2 clocks after the iorq_n falling edge (input register plus LATCH).
  - Local access: wait_n is low for 1+LOCAL_WAITS+1 clocks in total.
  - Bus access: minimum release is BUS_MIN_WAITS+1 clocks after BUS entry.
- port_addr and wr_data stay stable from LATCH until the next LATCH.
- Exactly one strobe per accepted cycle. No strobe is issued for an ignored cycle or for interrupt acknowledge.
- If iorq_n rises early (before RELEASE), the cycle still runs to completion: no truncation, no second strobe.
- timeout_err is cleared only by reset.
- Counter widths: 4 bits for the wait counter, 8 bits for the timeout counter. Counters saturate and never wrap.

Decomposition:
- Shared package z80_io_pkg holds:
  - FSM state encoding: IDLE, LATCH, LOCAL, BUS, RELEASE.
  - Direction constants DIR_RD and DIR_WR.
  - Default wait and timeout constants.
- One natural sub-module: io_cycle_detect. It registers iorq_n, rd_n, wr_n and m1_n, then outputs a one-clock start pulse and the decoded direction.

Test Plan:
- Local write: out (0xFF),0x5A with local_sel=1 and LOCAL_WAITS=1. Expect port_addr=0xFF, wr_data=0x5A, one io_wr_strb pulse, wait_n low for 3 clocks, s100_cycle never high.
- Bus read: in 0x01 with local_sel=0, BUS_MIN_WAITS=2 and s100_rdy raised 5 clocks after BUS entry. Expect one io_rd_strb, s100_cycle high for 6 clocks, wait_n released the clock after RDY is sampled.
- Timeout: bus write with s100_rdy held 0 and BUS_TIMEOUT=8. Expect release after 8 clocks and timeout_err=1 until reset.
- Interrupt acknowledge: iorq_n low with m1_n low. Expect no strobe, wait_n=1, busy=0. A following normal IN must be served normally.
- Reset mid-cycle: assert reset while in BUS. Expect wait_n=1, s100_cycle=0, busy=0 on the next clock. With iorq_n still low after reset, no new cycle may start.
- RDY on the timeout clock: s100_rdy rises exactly at count BUS_TIMEOUT. Expect a normal release with timeout_err=0.

Source files
------------

// File: rtl/z80_io_pkg.sv
// Shared types and defaults for the Z80 I/O cycle sequencer on the T35 board.
package z80_io_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LATCH   = 3'd1,
      LOCAL   = 3'd2,
      BUS     = 3'd3,
      RELEASE = 3'd4
   } io_state_t;

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } io_dir_t;

   localparam int DEF_LOCAL_WAITS   = 1;
   localparam int DEF_BUS_MIN_WAITS = 2;
   localparam int DEF_BUS_TIMEOUT   = 255;

endpackage

// File: rtl/io_cycle_detect.sv
// Registers the Z80 control pins and flags the start of an IORQ read/write cycle.
module io_cycle_detect
   import z80_io_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    iorq_n,
   input  logic    rd_n,
   input  logic    wr_n,
   input  logic    m1_n,
   output logic    start,
   output io_dir_t dir
);

   logic iorq_n_p0, iorq_n_p1;
   logic rd_n_p0, wr_n_p0, m1_n_p0;

   // Stage p0: input register; p1: previous IORQ for edge detection.
   // IORQ history resets low so a pin still held low after reset is not an edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         iorq_n_p0 <= 1'b0;
         iorq_n_p1 <= 1'b0;
         rd_n_p0   <= 1'b1;
         wr_n_p0   <= 1'b1;
         m1_n_p0   <= 1'b1;
      end else begin
         iorq_n_p0 <= iorq_n;
         iorq_n_p1 <= iorq_n_p0;
         rd_n_p0   <= rd_n;
         wr_n_p0   <= wr_n;
         m1_n_p0   <= m1_n;
      end
   end

   assign start = iorq_n_p1 & ~iorq_n_p0 & m1_n_p0 & (rd_n_p0 ^ wr_n_p0);
   assign dir   = wr_n_p0 ? DIR_RD : DIR_WR;

endmodule

// File: rtl/z80_io_sequencer.sv
// Z80 I/O cycle sequencer: holds WAIT while a T35-internal or S100 port serves the access.
module z80_io_sequencer
   import z80_io_pkg::*;
#(
   parameter int LOCAL_WAITS   = DEF_LOCAL_WAITS,
   parameter int BUS_MIN_WAITS = DEF_BUS_MIN_WAITS,
   parameter int BUS_TIMEOUT   = DEF_BUS_TIMEOUT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       m1_n,
   input  logic [7:0] address,
   input  logic [7:0] cpu_dout,
   input  logic       local_sel,
   input  logic       s100_rdy,
   output logic       wait_n,
   output logic [7:0] port_addr,
   output logic [7:0] wr_data,
   output logic       io_rd_strb,
   output logic       io_wr_strb,
   output logic       s100_cycle,
   output logic       busy,
   output logic       timeout_err
);

   localparam logic [3:0] LOCAL_WAITS_C   = 4'(LOCAL_WAITS);
   localparam logic [3:0] BUS_MIN_WAITS_C = 4'(BUS_MIN_WAITS);
   localparam logic [7:0] BUS_TIMEOUT_C   = 8'(BUS_TIMEOUT);

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   io_state_t  state, state_nxt;
   io_dir_t    dir, dir_q;
   logic       start, local_q;
   logic [3:0] wait_cnt;
   logic [7:0] to_cnt;
   logic       first_clk, rdy_ok, to_hit;

   io_cycle_detect u_detect (
      .clock  (clock),
      .reset  (reset),
      .iorq_n (iorq_n),
      .rd_n   (rd_n),
      .wr_n   (wr_n),
      .m1_n   (m1_n),
      .start  (start),
      .dir    (dir)
   );

   // wait_cnt counts clocks spent in LOCAL/BUS; to_cnt holds clocks elapsed in BUS.
   assign first_clk = (wait_cnt == 4'd0);
   assign rdy_ok    = s100_rdy && (wait_cnt >= BUS_MIN_WAITS_C);
   assign to_hit    = (to_cnt >= BUS_TIMEOUT_C);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LATCH;
         LATCH:   state_nxt = local_q ? LOCAL : BUS;
         LOCAL:   if (wait_cnt >= LOCAL_WAITS_C) state_nxt = RELEASE;
         BUS:     if (rdy_ok || to_hit) state_nxt = RELEASE;
         RELEASE: if (iorq_n) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         port_addr   <= 8'd0;
         wr_data     <= 8'd0;
         dir_q       <= DIR_RD;
         local_q     <= 1'b0;
         wait_cnt    <= 4'd0;
         to_cnt      <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            port_addr <= address;
            dir_q     <= dir;
            local_q   <= local_sel;
            if (dir == DIR_WR) wr_data <= cpu_dout;
         end
         if (state == LOCAL || state == BUS) wait_cnt <= sat_inc4(wait_cnt);
         else                                wait_cnt <= 4'd0;
         if (state == LATCH)    to_cnt <= 8'd1;
         else if (state == BUS) to_cnt <= sat_inc8(to_cnt);
         else                   to_cnt <= 8'd0;
         // RDY arriving on the timeout clock wins over the timeout.
         if (state == BUS && to_hit && !rdy_ok) timeout_err <= 1'b1;
      end
   end

   always_comb begin
      wait_n     = 1'b1;
      io_rd_strb = 1'b0;
      io_wr_strb = 1'b0;
      s100_cycle = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE:  busy = 1'b0;
         LATCH: wait_n = 1'b0;
         LOCAL: begin
            wait_n     = 1'b0;
            io_rd_strb = first_clk && (dir_q == DIR_RD);
            io_wr_strb = first_clk && (dir_q == DIR_WR);
         end
         BUS: begin
            wait_n     = 1'b0;
            s100_cycle = 1'b1;
            io_rd_strb = first_clk && (dir_q == DIR_RD);
            io_wr_strb = first_clk && (dir_q == DIR_WR);
         end
         RELEASE: ;
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_z80_io_sequencer.sv
// Directed bench for z80_io_sequencer with LOCAL_WAITS=1, BUS_MIN_WAITS=2, BUS_TIMEOUT=8.
module tb_z80_io_sequencer;

   logic       clock = 1'b0;
   logic       reset, iorq_n, rd_n, wr_n, m1_n, local_sel, s100_rdy;
   logic [7:0] address, cpu_dout;
   logic       wait_n, io_rd_strb, io_wr_strb, s100_cycle, busy, timeout_err;
   logic [7:0] port_addr, wr_data;

   z80_io_sequencer #(
      .LOCAL_WAITS   (1),
      .BUS_MIN_WAITS (2),
      .BUS_TIMEOUT   (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .iorq_n      (iorq_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .m1_n        (m1_n),
      .address     (address),
      .cpu_dout    (cpu_dout),
      .local_sel   (local_sel),
      .s100_rdy    (s100_rdy),
      .wait_n      (wait_n),
      .port_addr   (port_addr),
      .wr_data     (wr_data),
      .io_rd_strb  (io_rd_strb),
      .io_wr_strb  (io_wr_strb),
      .s100_cycle  (s100_cycle),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int ncyc, first_low, c_wait, c_rd, c_wr, c_s100, c_busy;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clr();
      ncyc = 0; first_low = 0; c_wait = 0; c_rd = 0; c_wr = 0; c_s100 = 0; c_busy = 0;
   endtask

   // Advance n clocks, sampling 1 time unit after each rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         ncyc++;
         if (!wait_n) begin
            c_wait++;
            if (first_low == 0) first_low = ncyc;
         end
         if (io_rd_strb) c_rd++;
         if (io_wr_strb) c_wr++;
         if (s100_cycle) c_s100++;
         if (busy) c_busy++;
      end
   endtask

   task automatic idle_bus();
      iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
   endtask

   task automatic io_start(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input logic loc);
      clr();
      iorq_n = 1'b0; rd_n = wr; wr_n = ~wr; m1_n = 1'b1;
      address = a; cpu_dout = d; local_sel = loc;
   endtask

   initial begin
      reset = 1'b1; s100_rdy = 1'b0; local_sel = 1'b0;
      address = 8'h00; cpu_dout = 8'h00;
      idle_bus();
      clr();
      step(2);
      chk("rst_wait_n", int'(wait_n), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_strb", int'({io_rd_strb, io_wr_strb}), 0);
      chk("rst_s100", int'(s100_cycle), 0);
      chk("rst_terr", int'(timeout_err), 0);
      chk("rst_addr", int'(port_addr), 0);
      chk("rst_wdata", int'(wr_data), 0);
      reset = 1'b0;
      step(2);

      // Local write OUT (0xFF),0x5A
      io_start(1'b1, 8'hFF, 8'h5A, 1'b1);
      step(6);
      chk("lw_first_low", first_low, 2);
      chk("lw_wait_cnt", c_wait, 3);
      chk("lw_wr_strb", c_wr, 1);
      chk("lw_rd_strb", c_rd, 0);
      chk("lw_s100", c_s100, 0);
      chk("lw_addr", int'(port_addr), 8'hFF);
      chk("lw_wdata", int'(wr_data), 8'h5A);
      chk("lw_hold_busy", int'(busy), 1);
      idle_bus();
      step(1);
      chk("lw_idle", int'(busy), 0);
      step(1);

      // Bus read IN 0x01, RDY raised 5 clocks after BUS entry
      io_start(1'b0, 8'h01, 8'h00, 1'b0);
      step(8);
      chk("br_wait_before", int'(wait_n), 0);
      s100_rdy = 1'b1;
      step(1);
      chk("br_wait_after", int'(wait_n), 1);
      chk("br_s100_cnt", c_s100, 6);
      chk("br_wait_cnt", c_wait, 7);
      chk("br_rd_strb", c_rd, 1);
      chk("br_wr_strb", c_wr, 0);
      chk("br_addr", int'(port_addr), 8'h01);
      chk("br_wdata_kept", int'(wr_data), 8'h5A);
      s100_rdy = 1'b0;
      idle_bus();
      step(2);
      chk("br_idle", int'(busy), 0);

      // Bus read with RDY already high: release after minimum waits
      s100_rdy = 1'b1;
      io_start(1'b0, 8'h10, 8'h00, 1'b0);
      step(5);
      chk("bm_wait_min", int'(wait_n), 0);
      step(1);
      chk("bm_release", int'(wait_n), 1);
      chk("bm_s100_cnt", c_s100, 3);
      s100_rdy = 1'b0;
      idle_bus();
      step(2);

      // IORQ rises early during BUS: cycle completes, one strobe only
      s100_rdy = 1'b1;
      io_start(1'b0, 8'h11, 8'h00, 1'b0);
      step(3);
      idle_bus();
      step(5);
      chk("er_rd_strb", c_rd, 1);
      chk("er_s100_cnt", c_s100, 3);
      chk("er_idle", int'(busy), 0);
      s100_rdy = 1'b0;

      // Ignored cycles: RD and WR both high, then both low
      io_start(1'b0, 8'h22, 8'h00, 1'b1);
      rd_n = 1'b1;
      step(4);
      idle_bus();
      step(2);
      io_start(1'b0, 8'h23, 8'h00, 1'b1);
      wr_n = 1'b0;
      step(4);
      chk("ign_busy", c_busy, 0);
      chk("ign_strb", c_rd + c_wr, 0);
      idle_bus();
      step(2);

      // Timeout on a bus write
      io_start(1'b1, 8'h80, 8'hC3, 1'b0);
      step(10);
      chk("to_err_before", int'(timeout_err), 0);
      chk("to_wait_before", int'(wait_n), 0);
      step(1);
      chk("to_err_set", int'(timeout_err), 1);
      chk("to_release", int'(wait_n), 1);
      chk("to_s100_cnt", c_s100, 8);
      chk("to_wr_strb", c_wr, 1);
      chk("to_wdata", int'(wr_data), 8'hC3);
      idle_bus();
      step(2);

      // Interrupt acknowledge is ignored, then a normal local IN is served
      io_start(1'b0, 8'h33, 8'h00, 1'b1);
      m1_n = 1'b0;
      step(5);
      chk("ia_busy", c_busy, 0);
      chk("ia_wait", c_wait, 0);
      chk("ia_strb", c_rd + c_wr, 0);
      idle_bus();
      step(2);
      io_start(1'b0, 8'h42, 8'h00, 1'b1);
      step(6);
      chk("ia_in_rd_strb", c_rd, 1);
      chk("ia_in_wait", c_wait, 3);
      chk("ia_in_addr", int'(port_addr), 8'h42);
      chk("terr_sticky", int'(timeout_err), 1);
      idle_bus();
      step(2);

      // Reset in the middle of a BUS cycle, IORQ held low afterwards
      io_start(1'b0, 8'h01, 8'h00, 1'b0);
      step(4);
      chk("mr_in_bus", int'(s100_cycle), 1);
      reset = 1'b1;
      step(1);
      chk("mr_wait_n", int'(wait_n), 1);
      chk("mr_s100", int'(s100_cycle), 0);
      chk("mr_busy", int'(busy), 0);
      chk("mr_terr", int'(timeout_err), 0);
      chk("mr_addr", int'(port_addr), 0);
      reset = 1'b0;
      clr();
      step(5);
      chk("mr_no_restart", c_busy, 0);
      chk("mr_no_strb", c_rd + c_wr, 0);
      idle_bus();
      step(2);

      // RDY arrives on exactly the timeout clock
      io_start(1'b0, 8'h20, 8'h00, 1'b0);
      step(10);
      s100_rdy = 1'b1;
      step(1);
      chk("rt_release", int'(wait_n), 1);
      chk("rt_terr", int'(timeout_err), 0);
      chk("rt_s100_cnt", c_s100, 8);
      s100_rdy = 1'b0;
      idle_bus();
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
